perceptron: RTL and testbench

PERCEPTRON -- requirements
Module: perceptron

---
 rtl/perceptron_pkg.sv | 17 +
 rtl/perceptron_mac.sv | 98 +++++++++
 rtl/perceptron.sv | 157 +++++++++++++++
 tb/tb_perceptron.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron block.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        RES,
        ERR,
        UPD,
        FBK
    } state_t;

    localparam int ACCW    = 32;
    localparam int WGTW    = 16;
    localparam int BIAS_IN = 255;

endpackage

// File: rtl/perceptron_mac.sv
// Sequential multiply-accumulate over the latched argument plus the
// saturating sign-step update of the weights and bias.
module perceptron_mac
    import perceptron_pkg::*;
#(
    parameter int ARGW = 8,
    parameter int ARGD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic                     upd,
    input  logic                     err_pos,
    input  logic                     err_neg,
    input  logic [ARGD*ARGW-1:0]     arg,
    output logic signed [ACCW-1:0]   acc,
    output logic                     done,
    output logic [ARGD*WGTW-1:0]     wgt
);

    localparam int IDXW = $clog2(ARGD + 1);
    localparam logic signed [WGTW+1:0] WMAX = (WGTW+2)'((64'sd1 <<< (WGTW - 1)) - 64'sd1);
    localparam logic signed [WGTW+1:0] WMIN = -WMAX - (WGTW+2)'(1);

    logic [ARGW-1:0]          x [ARGD];
    logic signed [WGTW-1:0]   w [ARGD];
    logic signed [WGTW-1:0]   b;
    logic [IDXW-1:0]          idx;
    logic signed [ACCW-1:0]   term;

    function automatic logic signed [WGTW-1:0] sat_w(input logic signed [WGTW+1:0] v);
        if (v > WMAX)
            return WMAX[WGTW-1:0];
        else if (v < WMIN)
            return WMIN[WGTW-1:0];
        else
            return v[WGTW-1:0];
    endfunction

    function automatic logic signed [WGTW-1:0] step_w(input logic signed [WGTW-1:0] cur,
                                                      input logic [WGTW-1:0]        mag,
                                                      input logic                   pos,
                                                      input logic                   neg);
        logic signed [WGTW+1:0] c;
        logic signed [WGTW+1:0] m;
        c = (WGTW+2)'(cur);
        m = (WGTW+2)'($signed({1'b0, mag}));
        if (pos)
            return sat_w(c + m);
        else if (neg)
            return sat_w(c - m);
        else
            return cur;
    endfunction

    // idx 0 contributes the bias term, idx i+1 contributes element i
    always_comb begin
        term = ACCW'(b) * ACCW'(BIAS_IN);
        for (int i = 0; i < ARGD; i++) begin
            if (idx == IDXW'(i + 1))
                term = ACCW'(w[i]) * ACCW'($signed({1'b0, x[i]}));
        end
    end

    assign done = step && (idx == IDXW'(ARGD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARGD; i++) begin
                x[i] <= '0;
                w[i] <= '0;
            end
            b   <= WGTW'(-BIAS_IN);
            idx <= '0;
            acc <= '0;
        end else begin
            if (start) begin
                for (int i = 0; i < ARGD; i++)
                    x[i] <= arg[i*ARGW +: ARGW];
                idx <= '0;
            end else if (step) begin
                acc <= (idx == '0) ? term : acc + term;
                idx <= idx + 1'b1;
            end
            if (upd) begin
                for (int i = 0; i < ARGD; i++)
                    w[i] <= step_w(w[i], WGTW'(x[i]), err_pos, err_neg);
                b <= step_w(b, WGTW'(BIAS_IN), err_pos, err_neg);
            end
        end
    end

    for (genvar g = 0; g < ARGD; g++) begin : g_wgt
        assign wgt[g*WGTW +: WGTW] = w[g];
    end

endmodule

// File: rtl/perceptron.sv
// Single perceptron with step activation and online sign-step training.
// Optional back-propagated error output is enabled by PERCEPTRON_FEEDBACK_EN.
module perceptron
    import perceptron_pkg::*;
#(
    parameter int ARGW = 8,
    parameter int ARGD = 2,
    parameter int RESW = 8,
    parameter int ERRW = 16,
    parameter int FBKW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ARGD*ARGW-1:0] arg_dat,
    input  logic                 arg_stb,
    output logic                 arg_rdy,
    output logic [RESW-1:0]      res_dat,
    output logic                 res_stb,
    input  logic                 res_rdy,
    input  logic [ERRW-1:0]      err_dat,
    input  logic                 err_stb,
    output logic                 err_rdy,
    output logic [ARGD*FBKW-1:0] fbk_dat,
    output logic                 fbk_stb,
    input  logic                 fbk_rdy
);

    state_t                  state;
    state_t                  state_next;
    logic                    live;
    logic                    en_q;
    logic signed [ERRW-1:0]  err_q;
    logic signed [ACCW-1:0]  acc;
    logic                    done;
    logic [ARGD*WGTW-1:0]    wgt;
    logic                    upd;
    logic                    arg_fire;
    logic                    err_fire;

    assign arg_fire = arg_stb && arg_rdy;
    assign err_fire = err_stb && err_rdy;

    // live keeps arg_rdy low while reset is held and for the release edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            live  <= 1'b0;
            en_q  <= 1'b0;
            err_q <= '0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
            if (arg_fire)
                en_q <= en;
            if (err_fire)
                err_q <= $signed(err_dat);
        end
    end

    always_comb begin
        state_next = state;
        arg_rdy    = 1'b0;
        res_stb    = 1'b0;
        err_rdy    = 1'b0;
        fbk_stb    = 1'b0;
        upd        = 1'b0;
        case (state)
            IDLE: begin
                arg_rdy = live;
                if (arg_stb && live)
                    state_next = MAC;
            end
            MAC: begin
                if (done)
                    state_next = RES;
            end
            RES: begin
                res_stb = 1'b1;
                if (res_rdy)
                    state_next = en_q ? ERR : IDLE;
            end
            ERR: begin
                err_rdy = 1'b1;
                if (err_stb)
                    state_next = UPD;
            end
            UPD: begin
                upd = 1'b1;
`ifdef PERCEPTRON_FEEDBACK_EN
                state_next = FBK;
`else
                state_next = IDLE;
`endif
            end
`ifdef PERCEPTRON_FEEDBACK_EN
            FBK: begin
                fbk_stb = 1'b1;
                if (fbk_rdy)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign res_dat = (acc > 0) ? '1 : '0;

    perceptron_mac #(
        .ARGW (ARGW),
        .ARGD (ARGD)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .start   (arg_fire),
        .step    (state == MAC),
        .upd     (upd),
        .err_pos (err_q > 0),
        .err_neg (err_q < 0),
        .arg     (arg_dat),
        .acc     (acc),
        .done    (done),
        .wgt     (wgt)
    );

`ifdef PERCEPTRON_FEEDBACK_EN
    localparam int PW = ERRW + WGTW;
    localparam logic signed [PW-1:0] FMAX = PW'((64'sd1 <<< (FBKW - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] FMIN = -FMAX - PW'(1);

    function automatic logic [FBKW-1:0] sat_fbk(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] s;
        s = v >>> 8;
        if (s > FMAX)
            return FMAX[FBKW-1:0];
        else if (s < FMIN)
            return FMIN[FBKW-1:0];
        else
            return s[FBKW-1:0];
    endfunction

    // captured on the UPD edge, so it sees the weights before they move
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fbk_dat <= '0;
        end else if (upd) begin
            for (int i = 0; i < ARGD; i++)
                fbk_dat[i*FBKW +: FBKW] <= sat_fbk(PW'(err_q) * PW'($signed(wgt[i*WGTW +: WGTW])));
        end
    end
`else
    logic unused_fbk;
    assign unused_fbk = ^{wgt, fbk_rdy};
    assign fbk_dat    = '0;
`endif

endmodule

// File: tb/tb_perceptron.sv
// Directed bench for perceptron: inference, AND training, handshake stalls,
// reset abort and weight saturation.
module tb_perceptron;

    localparam int ARGW = 8;
    localparam int ARGD = 2;
    localparam int RESW = 8;
    localparam int ERRW = 16;
    localparam int FBKW = 16;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [ARGD*ARGW-1:0] arg_dat;
    logic                 arg_stb;
    logic                 arg_rdy;
    logic [RESW-1:0]      res_dat;
    logic                 res_stb;
    logic                 res_rdy;
    logic [ERRW-1:0]      err_dat;
    logic                 err_stb;
    logic                 err_rdy;
    logic [ARGD*FBKW-1:0] fbk_dat;
    logic                 fbk_stb;
    logic                 fbk_rdy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  r;
    logic [31:0] f;

    // expected result pattern per AND epoch, bit p set -> res FF for pattern p
    logic [3:0] and_mask [10] = '{4'b0000, 4'b0010, 4'b0110, 4'b0100, 4'b1010,
                                  4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};

    perceptron #(
        .ARGW (ARGW),
        .ARGD (ARGD),
        .RESW (RESW),
        .ERRW (ERRW),
        .FBKW (FBKW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .arg_dat (arg_dat),
        .arg_stb (arg_stb),
        .arg_rdy (arg_rdy),
        .res_dat (res_dat),
        .res_stb (res_stb),
        .res_rdy (res_rdy),
        .err_dat (err_dat),
        .err_stb (err_stb),
        .err_rdy (err_rdy),
        .fbk_dat (fbk_dat),
        .fbk_stb (fbk_stb),
        .fbk_rdy (fbk_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, " arg_rdy"}, {31'b0, arg_rdy}, 32'd0);
        check({tag, " res_stb"}, {31'b0, res_stb}, 32'd0);
        check({tag, " err_rdy"}, {31'b0, err_rdy}, 32'd0);
        check({tag, " fbk_stb"}, {31'b0, fbk_stb}, 32'd0);
        check({tag, " res_dat"}, {24'b0, res_dat}, 32'd0);
        check({tag, " fbk_dat"}, fbk_dat, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check({tag, " arg_rdy after release"}, {31'b0, arg_rdy}, 32'd1);
    endtask

    // hands over one argument and waits for res_stb without consuming it
    task automatic send_arg(input logic [7:0] x0, input logic [7:0] x1, input logic en_acc,
                            input logic en_after, input string tag, output logic [7:0] res);
        int   n;
        logic rdy_s;
        arg_dat = {x1, x0};
        arg_stb = 1'b1;
        en      = en_acc;
        n = 0;
        do begin
            rdy_s = arg_rdy;
            tick();
            n++;
        end while (!rdy_s && n < 50);
        arg_stb = 1'b0;
        en      = en_after;
        check({tag, " accept"}, {31'b0, rdy_s}, 32'd1);
        n = 0;
        while (!res_stb && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, ARGD + 1);
        res = res_dat;
    endtask

    task automatic take_res();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
    endtask

    task automatic send_err(input logic [15:0] e, input string tag, output logic [31:0] fb);
        int n;
        n = 0;
        while (!err_rdy && n < 10) begin
            tick();
            n++;
        end
        check({tag, " err_rdy"}, {31'b0, err_rdy}, 32'd1);
        err_dat = e;
        err_stb = 1'b1;
        tick();
        err_stb = 1'b0;
`ifdef PERCEPTRON_FEEDBACK_EN
        n = 0;
        while (!fbk_stb && n < 10) begin
            tick();
            n++;
        end
        check({tag, " fbk_stb"}, {31'b0, fbk_stb}, 32'd1);
`else
        tick();
        check({tag, " fbk_stb tied"}, {31'b0, fbk_stb}, 32'd0);
        check({tag, " fbk_dat tied"}, fbk_dat, 32'd0);
`endif
        fb = fbk_dat;
    endtask

    task automatic take_fbk();
`ifdef PERCEPTRON_FEEDBACK_EN
        fbk_rdy = 1'b1;
        tick();
        fbk_rdy = 1'b0;
`endif
    endtask

    task automatic train_and(input string tag);
        logic [7:0]  res;
        logic [7:0]  tgt;
        logic [7:0]  exp_res;
        logic [15:0] ev;
        logic [31:0] fb;
        for (int ep = 0; ep < 10; ep++) begin
            for (int p = 0; p < 4; p++) begin
                tgt     = (p == 3) ? 8'hFF : 8'h00;
                exp_res = and_mask[ep][p] ? 8'hFF : 8'h00;
                send_arg(p[0] ? 8'hFF : 8'h00, p[1] ? 8'hFF : 8'h00, 1'b1, 1'b1, tag, res);
                check($sformatf("%s ep%0d p%0d res", tag, ep, p), {24'b0, res}, {24'b0, exp_res});
                take_res();
                ev = {8'h00, tgt} - {8'h00, exp_res};
                send_err(ev, tag, fb);
`ifdef PERCEPTRON_FEEDBACK_EN
                if (ev == 16'd0)
                    check($sformatf("%s ep%0d p%0d fbk zero", tag, ep, p), fb, 32'd0);
                if (ep == 1 && p == 1)
                    check({tag, " fbk ep1 p1"}, fb, 32'hFF01_FF01);
`endif
                take_fbk();
            end
        end
        for (int p = 0; p < 4; p++) begin
            send_arg(p[0] ? 8'hFF : 8'h00, p[1] ? 8'hFF : 8'h00, 1'b0, 1'b0, tag, res);
            check($sformatf("%s final p%0d", tag, p), {24'b0, res}, (p == 3) ? 32'hFF : 32'h00);
            take_res();
            check($sformatf("%s final p%0d no err", tag, p), {31'b0, err_rdy}, 32'd0);
            check($sformatf("%s final p%0d idle", tag, p), {31'b0, arg_rdy}, 32'd1);
        end
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        arg_dat = '0;
        arg_stb = 1'b0;
        res_rdy = 1'b0;
        err_dat = '0;
        err_stb = 1'b0;
        fbk_rdy = 1'b0;

        do_reset("rst0");

        // untrained inference: every input gives 00, no error handshake
        for (int p = 0; p < 4; p++) begin
            send_arg(p[0] ? 8'hFF : 8'h00, p[1] ? 8'hFF : 8'h00, 1'b0, 1'b0, "untrained", r);
            check($sformatf("untrained p%0d res", p), {24'b0, r}, 32'h00);
            take_res();
            check($sformatf("untrained p%0d no err", p), {31'b0, err_rdy}, 32'd0);
        end

        train_and("and1");

        // reset while waiting for the error: weights must go back to reset values
        send_arg(8'hFF, 8'hFF, 1'b1, 1'b1, "abort", r);
        check("abort res", {24'b0, r}, 32'hFF);
        take_res();
        check("abort in err", {31'b0, err_rdy}, 32'd1);
        rst = 1'b0;
        #2;
        check("abort err_rdy in reset", {31'b0, err_rdy}, 32'd0);
        check("abort arg_rdy in reset", {31'b0, arg_rdy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("abort arg_rdy after release", {31'b0, arg_rdy}, 32'd1);
        send_arg(8'hFF, 8'hFF, 1'b0, 1'b0, "abort reinit", r);
        check("abort reinit res", {24'b0, r}, 32'h00);
        take_res();

        train_and("and2");

        // single-step training; en dropped right after acceptance
        do_reset("rst1");
        send_arg(8'hFF, 8'hFF, 1'b1, 1'b0, "step1", r);
        check("step1 res", {24'b0, r}, 32'h00);
        take_res();
        send_err(16'd255, "step1", f);
`ifdef PERCEPTRON_FEEDBACK_EN
        check("step1 fbk", f, 32'd0);
`endif
        take_fbk();
        send_arg(8'hFF, 8'hFF, 1'b1, 1'b1, "step2", r);
        check("step2 res", {24'b0, r}, 32'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("res stall %0d stb", i), {31'b0, res_stb}, 32'd1);
            check($sformatf("res stall %0d dat", i), {24'b0, res_dat}, 32'hFF);
            check($sformatf("res stall %0d err_rdy", i), {31'b0, err_rdy}, 32'd0);
        end
        take_res();
        send_err(16'hFF01, "step2", f);
`ifdef PERCEPTRON_FEEDBACK_EN
        check("step2 fbk", f, 32'hFF01_FF01);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fbk stall %0d stb", i), {31'b0, fbk_stb}, 32'd1);
            check($sformatf("fbk stall %0d dat", i), fbk_dat, 32'hFF01_FF01);
            check($sformatf("fbk stall %0d arg_rdy", i), {31'b0, arg_rdy}, 32'd0);
        end
`endif
        take_fbk();
        send_arg(8'hFF, 8'h00, 1'b0, 1'b0, "step3", r);
        check("step3 res", {24'b0, r}, 32'h00);
        take_res();

        // drive the weights into the positive 16-bit limit
        do_reset("rst2");
        for (int k = 0; k < 131; k++) begin
            send_arg(8'hFF, 8'hFF, 1'b1, 1'b1, "sat", r);
            check($sformatf("sat k%0d res", k), {24'b0, r}, (k == 0) ? 32'h00 : 32'hFF);
            take_res();
            send_err(16'd256, "sat", f);
`ifdef PERCEPTRON_FEEDBACK_EN
            check($sformatf("sat k%0d fbk", k), f,
                  {2{(k * 255 > 32767) ? 16'h7FFF : 16'(k * 255)}});
`endif
            take_fbk();
        end
        send_arg(8'hFF, 8'hFF, 1'b1, 1'b1, "fsat+", r);
        take_res();
        send_err(16'h7FFF, "fsat+", f);
`ifdef PERCEPTRON_FEEDBACK_EN
        check("fbk sat positive", f, 32'h7FFF_7FFF);
`endif
        take_fbk();
        send_arg(8'hFF, 8'hFF, 1'b1, 1'b1, "fsat-", r);
        take_res();
        send_err(16'h8000, "fsat-", f);
`ifdef PERCEPTRON_FEEDBACK_EN
        check("fbk sat negative", f, 32'h8000_8000);
`endif
        take_fbk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
